// File: rtl/pow_n_pipe.sv
// pow_n_pipe: pipelined unsigned integer power unit, o_res = i_n ** POW.
// S = POW-1 multiply stages, each with a valid bit, operand copy, partial
// product and sticky overflow flag. Valid/ready handshake on both sides,
// bubble-collapsing stalls, i_clk_en qualifies every register update.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset
//   i_clk_en     pipeline advance qualifier
//   i_n_vld      operand valid
//   o_n_rdy      operand accepted this cycle (combinational from i_res_rdy)
//   i_n          operand, unsigned, W bits
//   o_res_vld    result valid (last stage valid bit)
//   i_res_rdy    downstream accepts result
//   o_res        result, RW bits (registered)
//   o_ovf        result overflowed RW bits (registered)
//   o_stage_vld  per-stage valid bits, bit 0 = first stage
//
// Build option: define POW_N_PIPE_SAT_EN to saturate overflowed products to
// all ones; otherwise products wrap modulo 2**RW (o_ovf reported either way).

module pow_n_pipe #(
  parameter int unsigned W   = 8,
  parameter int unsigned RW  = 32,
  parameter int unsigned POW = 5
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_clk_en,
  input  logic            i_n_vld,
  output logic            o_n_rdy,
  input  logic [W-1:0]    i_n,
  output logic            o_res_vld,
  input  logic            i_res_rdy,
  output logic [RW-1:0]   o_res,
  output logic            o_ovf,
  output logic [POW-2:0]  o_stage_vld
);

  localparam int unsigned S   = POW - 1;
  localparam int unsigned PW  = RW + W;
  localparam int unsigned SQW = 2 * W;

  logic [S-1:0]  r_vld;
  logic [W-1:0]  r_n [S];
  logic [RW-1:0] r_p [S];
  logic [S-1:0]  r_o;

  logic [S-1:0]   w_adv;
  logic [RW-1:0]  w_p_nxt [S];
  logic [S-1:0]   w_o_nxt;
  logic [SQW-1:0] w_sq;

  // Advance chain: a stage moves if enabled and any stage from it to the
  // output is empty or the output is being taken (nested clk_en factors out).
  always_comb begin : adv_chain
    logic v_open;
    w_adv  = '0;
    v_open = i_res_rdy;
    for (int k = int'(S) - 1; k >= 0; k--) begin
      v_open   = v_open | ~r_vld[k];
      w_adv[k] = i_clk_en & v_open;
    end
  end

  // Next-state data for each stage: square at stage 0, multiply after.
  always_comb begin : next_data
    logic [PW-1:0] v_prod;
    v_prod     = '0;
    w_o_nxt    = '0;
    w_sq       = SQW'(i_n) * SQW'(i_n);
    w_p_nxt[0] = RW'(w_sq);
    for (int k = 1; k < int'(S); k++) begin
      v_prod     = PW'(r_p[k-1]) * PW'(r_n[k-1]);
      w_o_nxt[k] = r_o[k-1] | (|v_prod[PW-1:RW]);
`ifdef POW_N_PIPE_SAT_EN
      w_p_nxt[k] = w_o_nxt[k] ? {RW{1'b1}} : v_prod[RW-1:0];
`else
      w_p_nxt[k] = v_prod[RW-1:0];
`endif
    end
  end

  // Stage registers: load only on advance; reset wins over clk_en.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld <= '0;
      r_o   <= '0;
      for (int k = 0; k < int'(S); k++) begin
        r_n[k] <= '0;
        r_p[k] <= '0;
      end
    end else begin
      if (w_adv[0]) begin
        r_vld[0] <= i_n_vld;
        r_n[0]   <= i_n;
        r_p[0]   <= w_p_nxt[0];
        r_o[0]   <= w_o_nxt[0];
      end
      for (int k = 1; k < int'(S); k++) begin
        if (w_adv[k]) begin
          r_vld[k] <= r_vld[k-1];
          r_n[k]   <= r_n[k-1];
          r_p[k]   <= w_p_nxt[k];
          r_o[k]   <= w_o_nxt[k];
        end
      end
    end
  end

  assign o_n_rdy     = w_adv[0];
  assign o_res_vld   = r_vld[S-1];
  assign o_res       = r_p[S-1];
  assign o_ovf       = r_o[S-1];
  assign o_stage_vld = r_vld;

endmodule
